rgb_seq_ctrl: RTL and testbench
===============================

Name: rgb_seq_ctrl

Overview:
Sequencer for the board's three RGB LED channels. It generates the per-channel PWM enables that feed the SB_RGBA_DRV RGB0PWM/RGB1PWM/RGB2PWM inputs. Each colour step ramps brightness up, holds, ramps down and pauses, either as a single pass or cycling R->G->B(->W) until stopped. A start/stop/busy/done interface lets a top-level FSM or UART command decoder control it.

Parameters:
TICK_DIV, 12000, clk cycles per step tick (1 kHz at 12 MHz); must be >=2
PWM_BITS, 8, brightness/PWM counter width; level max LMAX = 2^PWM_BITS-1
HOLD_TICKS, 256, ticks spent at full brightness; must be >=1
GAP_TICKS, 64, ticks spent dark between colour steps; must be >=1

Ports:
clk  input  1  system clock, all logic on its rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a sequence; ignored while busy
stop  input  1  one-cycle request to end the sequence gracefully
mode  input  2  00 single pass of color_sel; 01 loop R,G,B; 10 loop R,G,B,W; 11 treated as 01
color_sel  input  3  channel mask {b,g,r} for mode 00
busy  output  1  high from the cycle after an accepted start until return to IDLE
done  output  1  one-cycle pulse on return to IDLE
pwm_r  output  1  PWM enable for red (RGB0PWM)
pwm_g  output  1  PWM enable for green (RGB1PWM)
pwm_b  output  1  PWM enable for blue (RGB2PWM)
state  output  3  current FSM state encoding, for debug

Behaviour:
- Reset: state=IDLE(0), busy=0, done=0, pwm_*=0, level=0, tick counter=0, PWM counter=0, step index=0.
- Encodings: IDLE=0, RAMP_UP=1, HOLD=2, RAMP_DOWN=3, GAP=4.
- PWM: free-running PWM_BITS counter pcnt. pwm_x = mask_x & (pcnt < level), registered. level=0 gives constant 0; level=LMAX gives high for LMAX of every 2^PWM_BITS cycles.
- Tick generator:
  - Counts 0..TICK_DIV-1 only when not IDLE; cleared to 0 in IDLE.
  - tick = (count == TICK_DIV-1). The first tick therefore falls TICK_DIV cycles after busy rises.
- Start:
  - start=1 in IDLE is sampled and latched into mode_q and color_q.
  - Next cycle: state=RAMP_UP, busy=1, level=0, step index=0.
  - mode 00 with color_sel=000: no sequence runs; stays IDLE, busy stays 0, done pulses the next cycle.
- Mask: mode 00 uses color_q. Looping modes use step 0=001, 1=010, 2=100, 3=111 (mode 10 only).
- Transitions, all taken only on tick except stop and the IDLE exit:
  - RAMP_UP: level+1. When the new level==LMAX -> HOLD, hold counter=0.
  - HOLD: hold counter+1. After HOLD_TICKS ticks -> RAMP_DOWN.
  - RAMP_DOWN: level-1. When the new level==0 -> GAP.
  - GAP: after GAP_TICKS ticks:
    - mode 00 -> IDLE.
    - Looping modes -> RAMP_UP with the step index advanced. Index wraps 2->0 (mode 01) or 3->0 (mode 10).
- Stop, sampled on any cycle while busy; stop_pend is set on the cycle stop is seen:
  - In RAMP_UP or HOLD: -> RAMP_DOWN next cycle, ramping down from the current level.
  - In RAMP_DOWN: continue ramping down.
  - In GAP: -> IDLE next cycle.
  - With stop_pend set, the RAMP_DOWN->GAP transition goes to IDLE instead.
- IDLE entry: busy=0, level=0, pwm_*=0, done=1 for exactly one cycle, stop_pend cleared.
- Simultaneous events:
  - start and stop together in IDLE: start ignored.
  - start while busy: ignored, latched mode/colour unchanged.
  - stop in IDLE: no effect.
- Mode and color_sel changes while busy have no effect.
- rst_n asserted mid-sequence: immediate return to reset values, no done pulse.
- Width rule: level never over- or underflows; it saturates at the transition points above.

Test Plan:
(All with TICK_DIV=4, PWM_BITS=3, HOLD_TICKS=2, GAP_TICKS=1.)
- Reset, then idle 20 cycles -> busy=0, done=0, pwm_*=0, state=0 throughout.
- mode=00, color_sel=001, start pulse -> busy rises the next cycle; done pulses and busy falls exactly 68 cycles later (17 ticks); pwm_g=pwm_b=0 throughout; pwm_r high 7 of 8 cycles during HOLD.
- mode=01, start, run 3 full steps -> pwm_r, pwm_g, pwm_b each active in turn, one 68-cycle step each; 4th step is red again; done never pulses.
- mode=10, stop pulse while in HOLD of step 3 (white) -> all three channels ramp down together from 7 to 0 in 7 ticks; then IDLE with a single done pulse, no GAP.
- mode=00, color_sel=000, start -> busy stays 0; done=1 on the following cycle only.
- Reset asserted mid-RAMP_UP at level=4 -> pwm_*=0 and state=0 immediately, no done; new start restarts from level=0.

Source files
------------

// File: rtl/rgb_seq_ctrl.sv
// rtl/rgb_seq_ctrl.sv - RGB LED brightness sequencer producing per-channel PWM enables
module rgb_seq_ctrl #(
   parameter int TICK_DIV   = 12000,
   parameter int PWM_BITS   = 8,
   parameter int HOLD_TICKS = 256,
   parameter int GAP_TICKS  = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       stop,
   input  logic [1:0] mode,
   input  logic [2:0] color_sel,
   output logic       busy,
   output logic       done,
   output logic       pwm_r,
   output logic       pwm_g,
   output logic       pwm_b,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_RAMP_UP   = 3'd1,
      S_HOLD      = 3'd2,
      S_RAMP_DOWN = 3'd3,
      S_GAP       = 3'd4
   } state_t;

   localparam int TW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int CMAX = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
   localparam int CW   = $clog2(CMAX + 1);

   localparam logic [TW-1:0]       TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [CW-1:0]       HOLD_LAST = CW'(HOLD_TICKS - 1);
   localparam logic [CW-1:0]       GAP_LAST  = CW'(GAP_TICKS - 1);
   localparam logic [PWM_BITS-1:0] LMAX      = '1;
   localparam logic [PWM_BITS-1:0] LMAX_M1   = PWM_BITS'((2 ** PWM_BITS) - 2);
   localparam logic [PWM_BITS-1:0] LVL_ONE   = PWM_BITS'(1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [TW-1:0]       r_tcnt;
   logic [PWM_BITS-1:0] r_pcnt;
   logic [PWM_BITS-1:0] r_level;
   logic [PWM_BITS-1:0] w_level_nxt;
   logic [CW-1:0]       r_cnt;
   logic [CW-1:0]       w_cnt_nxt;
   logic [1:0]          r_step;
   logic [1:0]          w_step_nxt;
   logic [1:0]          w_step_last;
   logic [1:0]          r_mode_q;
   logic [2:0]          r_color_q;
   logic                r_stop_pend;
   logic                w_stop_pend_nxt;
   logic                w_stop_now;
   logic                r_done;
   logic                w_done_nxt;
   logic                w_latch;
   logic                w_tick;
   logic [2:0]          w_mask;
   logic                w_lit;
   logic                r_pwm_r;
   logic                r_pwm_g;
   logic                r_pwm_b;

   assign busy  = (r_state != S_IDLE);
   assign done  = r_done;
   assign pwm_r = r_pwm_r;
   assign pwm_g = r_pwm_g;
   assign pwm_b = r_pwm_b;
   assign state = r_state;

   assign w_tick      = (r_tcnt == TICK_LAST);
   assign w_stop_now  = r_stop_pend | stop;
   assign w_step_last = (r_mode_q == 2'b10) ? 2'd3 : 2'd2;

   // Channel mask: explicit colour for single pass, fixed R,G,B(,W) rotation when looping
   always_comb begin
      w_mask = r_color_q;
      if (r_mode_q != 2'b00) begin
         case (r_step)
            2'd0:    w_mask = 3'b001;
            2'd1:    w_mask = 3'b010;
            2'd2:    w_mask = 3'b100;
            default: w_mask = 3'b111;
         endcase
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and datapath updates; brightness steps only on ticks, stop acts at once
   always_comb begin
      w_state_nxt     = r_state;
      w_level_nxt     = r_level;
      w_cnt_nxt       = r_cnt;
      w_step_nxt      = r_step;
      w_stop_pend_nxt = r_stop_pend | (stop & busy);
      w_done_nxt      = 1'b0;
      w_latch         = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_stop_pend_nxt = 1'b0;
            w_level_nxt     = '0;
            w_cnt_nxt       = '0;
            w_step_nxt      = 2'd0;
            if (start && !stop) begin
               w_latch = 1'b1;
               if ((mode == 2'b00) && (color_sel == 3'b000)) begin
                  w_done_nxt = 1'b1;
               end else begin
                  w_state_nxt = S_RAMP_UP;
               end
            end
         end
         S_RAMP_UP: begin
            if (stop) begin
               w_state_nxt = S_RAMP_DOWN;
            end else if (w_tick) begin
               if (r_level >= LMAX_M1) begin
                  w_level_nxt = LMAX;
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_HOLD;
               end else begin
                  w_level_nxt = r_level + LVL_ONE;
               end
            end
         end
         S_HOLD: begin
            if (stop) begin
               w_state_nxt = S_RAMP_DOWN;
            end else if (w_tick) begin
               if (r_cnt >= HOLD_LAST) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_RAMP_DOWN;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
         end
         S_RAMP_DOWN: begin
            if (w_tick) begin
               if (r_level <= LVL_ONE) begin
                  w_level_nxt = '0;
                  w_cnt_nxt   = '0;
                  if (w_stop_now) begin
                     w_state_nxt     = S_IDLE;
                     w_done_nxt      = 1'b1;
                     w_stop_pend_nxt = 1'b0;
                  end else begin
                     w_state_nxt = S_GAP;
                  end
               end else begin
                  w_level_nxt = r_level - LVL_ONE;
               end
            end
         end
         S_GAP: begin
            w_level_nxt = '0;
            if (w_stop_now) begin
               w_state_nxt     = S_IDLE;
               w_done_nxt      = 1'b1;
               w_stop_pend_nxt = 1'b0;
            end else if (w_tick) begin
               if (r_cnt >= GAP_LAST) begin
                  w_cnt_nxt = '0;
                  if (r_mode_q == 2'b00) begin
                     w_state_nxt     = S_IDLE;
                     w_done_nxt      = 1'b1;
                     w_stop_pend_nxt = 1'b0;
                  end else begin
                     w_state_nxt = S_RAMP_UP;
                     w_step_nxt  = (r_step >= w_step_last) ? 2'd0 : r_step + 2'd1;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt     = S_IDLE;
            w_level_nxt     = '0;
            w_stop_pend_nxt = 1'b0;
         end
      endcase
   end

   // Sequence registers; mode 11 is folded into 01 when latched
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_level     <= '0;
         r_cnt       <= '0;
         r_step      <= 2'd0;
         r_mode_q    <= 2'b00;
         r_color_q   <= 3'b000;
         r_stop_pend <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_level     <= w_level_nxt;
         r_cnt       <= w_cnt_nxt;
         r_step      <= w_step_nxt;
         r_stop_pend <= w_stop_pend_nxt;
         r_done      <= w_done_nxt;
         if (w_latch) begin
            r_mode_q  <= (mode == 2'b11) ? 2'b01 : mode;
            r_color_q <= color_sel;
         end
      end
   end

   // Step tick divider, held at zero while idle so the first tick lands TICK_DIV cycles in
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tcnt <= '0;
      end else if ((r_state == S_IDLE) || w_tick) begin
         r_tcnt <= '0;
      end else begin
         r_tcnt <= r_tcnt + 1'b1;
      end
   end

   // Free-running PWM period counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pcnt <= '0;
      end else begin
         r_pcnt <= r_pcnt + 1'b1;
      end
   end

   // Outputs are forced dark on the cycle the sequencer returns to idle
   assign w_lit = (w_state_nxt != S_IDLE) && (r_pcnt < r_level);

   // Registered PWM enables
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pwm_r <= 1'b0;
         r_pwm_g <= 1'b0;
         r_pwm_b <= 1'b0;
      end else begin
         r_pwm_r <= w_mask[0] & w_lit;
         r_pwm_g <= w_mask[1] & w_lit;
         r_pwm_b <= w_mask[2] & w_lit;
      end
   end

endmodule

// File: tb/tb_rgb_seq_ctrl.sv
// tb/tb_rgb_seq_ctrl.sv - directed self-checking bench for rgb_seq_ctrl
module tb_rgb_seq_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       stop;
   logic [1:0] mode;
   logic [2:0] color_sel;
   logic       busy;
   logic       done;
   logic       pwm_r;
   logic       pwm_g;
   logic       pwm_b;
   logic [2:0] state;

   int n_checks = 0;
   int n_fail   = 0;

   rgb_seq_ctrl #(
      .TICK_DIV   (4),
      .PWM_BITS   (3),
      .HOLD_TICKS (2),
      .GAP_TICKS  (1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .stop      (stop),
      .mode      (mode),
      .color_sel (color_sel),
      .busy      (busy),
      .done      (done),
      .pwm_r     (pwm_r),
      .pwm_g     (pwm_g),
      .pwm_b     (pwm_b),
      .state     (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Start pulse across one rising edge; returns at the observation point of cycle 0
   task automatic pulse_start(input logic [1:0] m, input logic [2:0] c);
      mode      = m;
      color_sel = c;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         n_checks++;
         if ({busy, done, pwm_r, pwm_g, pwm_b, state} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_idle cycle %0d: got %b want 00000000", c,
                     {busy, done, pwm_r, pwm_g, pwm_b, state});
         end
      end
   endtask

   task automatic test_single;
      int done_at = -1;
      int done_cnt = 0;
      int hold_n = 0;
      int hold_hi = 0;
      int gb = 0;
      logic early_r;
      logic busy67;
      logic busy68;
      logic [2:0] ps;
      pulse_start(2'b00, 3'b001);
      n_checks++;
      if ({busy, state} !== {1'b1, 3'd1}) begin
         n_fail++;
         $display("FAIL single_start: got busy=%0b state=%0d want busy=1 state=1", busy, state);
      end
      early_r = pwm_r;
      ps = state;
      busy67 = 1'b0;
      busy68 = 1'b1;
      for (int c = 1; c <= 75; c++) begin
         @(negedge clk);
         if (ps == 3'd2) begin
            hold_n++;
            hold_hi += int'(pwm_r);
         end
         if (pwm_g | pwm_b) gb++;
         if (c <= 4) early_r = early_r | pwm_r;
         if (done) begin
            done_cnt++;
            if (done_at < 0) done_at = c;
         end
         if (c == 67) busy67 = busy;
         if (c == 68) busy68 = busy;
         ps = state;
      end
      n_checks++;
      if (done_at != 68) begin
         n_fail++;
         $display("FAIL single_done_cycle: got %0d want 68", done_at);
      end
      n_checks++;
      if (done_cnt != 1) begin
         n_fail++;
         $display("FAIL single_done_count: got %0d want 1", done_cnt);
      end
      n_checks++;
      if ({busy67, busy68} !== 2'b10) begin
         n_fail++;
         $display("FAIL single_busy_fall: got %b want 10", {busy67, busy68});
      end
      n_checks++;
      if (gb != 0) begin
         n_fail++;
         $display("FAIL single_gb_dark: got %0d lit cycles want 0", gb);
      end
      n_checks++;
      if (hold_n != 8 || hold_hi != 7) begin
         n_fail++;
         $display("FAIL single_hold_duty: got %0d of %0d want 7 of 8", hold_hi, hold_n);
      end
      n_checks++;
      if (early_r !== 1'b0) begin
         n_fail++;
         $display("FAIL single_level0_dark: got %0b want 0", early_r);
      end
   endtask

   task automatic test_empty;
      pulse_start(2'b00, 3'b000);
      n_checks++;
      if ({busy, done, state} !== {1'b0, 1'b1, 3'd0}) begin
         n_fail++;
         $display("FAIL empty_done: got busy=%0b done=%0b state=%0d want 0 1 0", busy, done, state);
      end
      @(negedge clk);
      n_checks++;
      if ({busy, done} !== 2'b00) begin
         n_fail++;
         $display("FAIL empty_after: got busy=%0b done=%0b want 0 0", busy, done);
      end
   endtask

   task automatic test_idle_stop;
      mode      = 2'b00;
      color_sel = 3'b001;
      start     = 1'b1;
      stop      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      n_checks++;
      if ({busy, done, state} !== 5'd0) begin
         n_fail++;
         $display("FAIL start_with_stop: got busy=%0b done=%0b state=%0d want 0 0 0", busy, done, state);
      end
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({busy, done, state} !== 5'd0) begin
         n_fail++;
         $display("FAIL stop_in_idle: got busy=%0b done=%0b state=%0d want 0 0 0", busy, done, state);
      end
   endtask

   task automatic test_loop_rgb;
      int hits [4][3];
      int done_cnt = 0;
      int done_at = -1;
      logic busy_end;
      for (int k = 0; k < 4; k++)
         for (int j = 0; j < 3; j++) hits[k][j] = 0;
      pulse_start(2'b01, 3'b000);
      for (int c = 1; c <= 272; c++) begin
         if (c == 10) begin
            mode      = 2'b00;
            color_sel = 3'b100;
            start     = 1'b1;
         end
         @(negedge clk);
         start = 1'b0;
         hits[(c - 1) / 68][0] += int'(pwm_r);
         hits[(c - 1) / 68][1] += int'(pwm_g);
         hits[(c - 1) / 68][2] += int'(pwm_b);
         if (done) done_cnt++;
      end
      busy_end = busy;
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (hits[k][k % 3] == 0 || hits[k][(k + 1) % 3] != 0 || hits[k][(k + 2) % 3] != 0) begin
            n_fail++;
            $display("FAIL loop_step%0d: got r=%0d g=%0d b=%0d want only channel %0d lit",
                     k, hits[k][0], hits[k][1], hits[k][2], k % 3);
         end
      end
      n_checks++;
      if (done_cnt != 0 || busy_end !== 1'b1) begin
         n_fail++;
         $display("FAIL loop_no_done: got done_cnt=%0d busy=%0b want 0 1", done_cnt, busy_end);
      end
      stop = 1'b1;
      for (int c = 273; c <= 300; c++) begin
         @(negedge clk);
         stop = 1'b0;
         if (done) begin
            done_at = c;
            break;
         end
      end
      n_checks++;
      if (done_at != 276) begin
         n_fail++;
         $display("FAIL loop_stop_done: got %0d want 276", done_at);
      end
   endtask

   task automatic test_stop_white;
      int entries = 0;
      int entry_c = -1;
      int done_at = -1;
      int uneq = 0;
      int gaps = 0;
      int lit = 0;
      logic [2:0] ps;
      logic [2:0] pwm_at_done;
      pulse_start(2'b10, 3'b000);
      ps = state;
      for (int c = 1; c <= 400; c++) begin
         @(negedge clk);
         if (state == 3'd2 && ps != 3'd2) begin
            entries++;
            if (entries == 4) begin
               entry_c = c;
               break;
            end
         end
         ps = state;
      end
      n_checks++;
      if (entry_c != 232) begin
         n_fail++;
         $display("FAIL white_hold_entry: got %0d want 232", entry_c);
      end
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      n_checks++;
      if (state !== 3'd3) begin
         n_fail++;
         $display("FAIL white_stop_rampdown: got state=%0d want 3", state);
      end
      pwm_at_done = 3'b111;
      for (int c = 234; c <= 300; c++) begin
         @(negedge clk);
         if (done) begin
            done_at = c;
            pwm_at_done = {pwm_b, pwm_g, pwm_r};
            break;
         end
         if (!(pwm_r == pwm_g && pwm_g == pwm_b)) uneq++;
         if (state == 3'd4) gaps++;
         lit += int'(pwm_r);
      end
      n_checks++;
      if (done_at != 260) begin
         n_fail++;
         $display("FAIL white_done_cycle: got %0d want 260", done_at);
      end
      n_checks++;
      if (uneq != 0 || lit == 0) begin
         n_fail++;
         $display("FAIL white_together: got unequal=%0d lit=%0d want 0 and >0", uneq, lit);
      end
      n_checks++;
      if (gaps != 0 || pwm_at_done !== 3'b000) begin
         n_fail++;
         $display("FAIL white_no_gap: got gap_cycles=%0d pwm=%b want 0 000", gaps, pwm_at_done);
      end
      @(negedge clk);
      n_checks++;
      if ({busy, done, state} !== 5'd0) begin
         n_fail++;
         $display("FAIL white_single_done: got busy=%0b done=%0b state=%0d want 0 0 0", busy, done, state);
      end
   endtask

   task automatic test_reset_mid;
      int done_at = -1;
      int spur = 0;
      logic early_b;
      pulse_start(2'b00, 3'b100);
      repeat (17) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, pwm_r, pwm_g, pwm_b, state} !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_mid_immediate: got %b want 00000000",
                  {busy, done, pwm_r, pwm_g, pwm_b, state});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (done || busy) spur++;
      end
      n_checks++;
      if (spur != 0) begin
         n_fail++;
         $display("FAIL reset_mid_no_done: got %0d active cycles want 0", spur);
      end
      pulse_start(2'b00, 3'b100);
      early_b = pwm_b;
      for (int c = 1; c <= 80; c++) begin
         @(negedge clk);
         if (c <= 4) early_b = early_b | pwm_b;
         if (done) begin
            done_at = c;
            break;
         end
      end
      n_checks++;
      if (done_at != 68 || early_b !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_restart: got done_at=%0d early_b=%0b want 68 0", done_at, early_b);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      stop      = 1'b0;
      mode      = 2'b00;
      color_sel = 3'b000;
      test_reset;
      test_single;
      repeat (3) @(negedge clk);
      test_empty;
      test_idle_stop;
      test_loop_rgb;
      repeat (3) @(negedge clk);
      test_stop_white;
      repeat (3) @(negedge clk);
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
